// File: rtl/eq_band_mixer.sv
// Time-multiplexed stereo band mixer: slew-limited per-band gains, one shared
// multiplier for the band MAC and master volume, saturating W-bit output.
module eq_band_mixer #(
  parameter int NUM_BANDS = 5,
  parameter int W         = 16,
  parameter int GAIN_STEP = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      smpl_vld,
  input  logic [NUM_BANDS*W-1:0]    band_lft,
  input  logic [NUM_BANDS*W-1:0]    band_rght,
  input  logic [NUM_BANDS*12-1:0]   pot_band,
  input  logic [11:0]               pot_vol,
  input  logic                      clr_flags,
  output logic signed [W-1:0]       aud_out_lft,
  output logic signed [W-1:0]       aud_out_rght,
  output logic                      out_vld,
  output logic                      busy,
  output logic                      sat_flag,
  output logic                      ovr_flag
);

  localparam int CW = $clog2(NUM_BANDS);
  localparam int SW = CW + 1;
  localparam int AW = W + 13 + CW;
  localparam int MW = AW - 11;
  localparam int PW = MW + 13;
  localparam logic [SW-1:0] LAST_STEP = SW'(2 * NUM_BANDS - 1);
  localparam logic [11:0]   STEP12    = 12'(GAIN_STEP);
  localparam logic signed [PW-1:0] OUT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] OUT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, VOL_L, VOL_R, OUT} state_t;

  state_t state, state_nxt;

  logic signed [W-1:0]  smp_l [NUM_BANDS];
  logic signed [W-1:0]  smp_r [NUM_BANDS];
  logic [11:0]          gain     [NUM_BANDS];
  logic [11:0]          gain_nxt [NUM_BANDS];
  logic [11:0]          vol_q;
  logic signed [AW-1:0] acc_l, acc_r;
  logic [SW-1:0]        step;
  logic [CW-1:0]        band_idx;
  logic signed [W-1:0]  res_l;
  logic                 sat_l;

  logic signed [W-1:0]  mac_smp;
  logic signed [MW-1:0] mul_a;
  logic signed [12:0]   mul_b;
  logic signed [PW-1:0] mul_p;
  logic signed [PW-1:0] vol_p;
  logic                 sat_hi, sat_lo;
  logic signed [W-1:0]  sat_val;
  logic                 sat_set, ovr_set;

  logic [11:0]          pot_k;
  int                   diff;

  assign band_idx = step[SW-1:1];
  assign out_vld  = (state == OUT);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (smpl_vld) state_nxt = MAC;
      MAC:     if (step == LAST_STEP) state_nxt = VOL_L;
      VOL_L:   state_nxt = VOL_R;
      VOL_R:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Each gain moves toward its pot by at most GAIN_STEP per accepted sample.
  always_comb begin
    pot_k = '0;
    diff  = 0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      pot_k = pot_band[k*12 +: 12];
      diff  = int'(pot_k) - int'(gain[k]);
      if (GAIN_STEP == 0 || (diff <= GAIN_STEP && diff >= -GAIN_STEP))
        gain_nxt[k] = pot_k;
      else if (diff > 0)
        gain_nxt[k] = gain[k] + STEP12;
      else
        gain_nxt[k] = gain[k] - STEP12;
    end
  end

  always_comb begin
    mac_smp = step[0] ? smp_r[band_idx] : smp_l[band_idx];
    mul_a   = '0;
    mul_b   = '0;
    case (state)
      MAC: begin
        mul_a = {{(MW-W){mac_smp[W-1]}}, mac_smp};
        mul_b = {1'b0, gain[band_idx]};
      end
      VOL_L: begin
        mul_a = acc_l[AW-1:11];
        mul_b = {1'b0, vol_q};
      end
      VOL_R: begin
        mul_a = acc_r[AW-1:11];
        mul_b = {1'b0, vol_q};
      end
      default: ;
    endcase
    mul_p = mul_a * mul_b;
  end

  always_comb begin
    vol_p   = mul_p >>> 12;
    sat_hi  = (vol_p > OUT_MAX);
    sat_lo  = (vol_p < OUT_MIN);
    sat_val = vol_p[W-1:0];
    if (sat_hi)      sat_val = OUT_MAX[W-1:0];
    else if (sat_lo) sat_val = OUT_MIN[W-1:0];
    sat_set = (state == VOL_R) && (sat_l || sat_hi || sat_lo);
    ovr_set = smpl_vld && (state != IDLE);
  end

  // Left result is parked until the right one is ready so both outputs change together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        smp_l[k] <= '0;
        smp_r[k] <= '0;
        gain[k]  <= 12'd2048;
      end
      vol_q        <= '0;
      acc_l        <= '0;
      acc_r        <= '0;
      step         <= '0;
      res_l        <= '0;
      sat_l        <= 1'b0;
      aud_out_lft  <= '0;
      aud_out_rght <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (smpl_vld) begin
            for (int k = 0; k < NUM_BANDS; k++) begin
              smp_l[k] <= band_lft[k*W +: W];
              smp_r[k] <= band_rght[k*W +: W];
              gain[k]  <= gain_nxt[k];
            end
            vol_q <= pot_vol;
            acc_l <= '0;
            acc_r <= '0;
            step  <= '0;
          end
        end
        MAC: begin
          if (step[0]) acc_r <= acc_r + mul_p[AW-1:0];
          else         acc_l <= acc_l + mul_p[AW-1:0];
          step <= step + 1'b1;
        end
        VOL_L: begin
          res_l <= sat_val;
          sat_l <= sat_hi || sat_lo;
        end
        VOL_R: begin
          aud_out_lft  <= res_l;
          aud_out_rght <= sat_val;
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle beats clr_flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end else begin
      if (sat_set)        sat_flag <= 1'b1;
      else if (clr_flags) sat_flag <= 1'b0;
      if (ovr_set)        ovr_flag <= 1'b1;
      else if (clr_flags) ovr_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// Scoreboard bench for eq_band_mixer: default 5-band instance plus an
// 8-band instance with immediate gain tracking.
module tb_eq_band_mixer;

  localparam int NB  = 5;
  localparam int NB8 = 8;
  localparam int W   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, smpl_vld, clr_flags;
  logic [NB*W-1:0]        band_lft, band_rght;
  logic [NB*12-1:0]       pot_band;
  logic [11:0]            pot_vol;
  logic signed [W-1:0]    aud_out_lft, aud_out_rght;
  logic                   out_vld, busy, sat_flag, ovr_flag;

  logic                   smpl_vld8, clr_flags8;
  logic [NB8*W-1:0]       band8_lft, band8_rght;
  logic [NB8*12-1:0]      pot8_band;
  logic [11:0]            pot8_vol;
  logic signed [W-1:0]    aud8_lft, aud8_rght;
  logic                   out8_vld, busy8, sat8_flag, ovr8_flag;

  eq_band_mixer #(.NUM_BANDS(NB), .W(W), .GAIN_STEP(256)) dut (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld),
    .band_lft(band_lft), .band_rght(band_rght),
    .pot_band(pot_band), .pot_vol(pot_vol), .clr_flags(clr_flags),
    .aud_out_lft(aud_out_lft), .aud_out_rght(aud_out_rght),
    .out_vld(out_vld), .busy(busy), .sat_flag(sat_flag), .ovr_flag(ovr_flag)
  );

  eq_band_mixer #(.NUM_BANDS(NB8), .W(W), .GAIN_STEP(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .smpl_vld(smpl_vld8),
    .band_lft(band8_lft), .band_rght(band8_rght),
    .pot_band(pot8_band), .pot_vol(pot8_vol), .clr_flags(clr_flags8),
    .aud_out_lft(aud8_lft), .aud_out_rght(aud8_rght),
    .out_vld(out8_vld), .busy(busy8), .sat_flag(sat8_flag), .ovr_flag(ovr8_flag)
  );

  typedef struct {
    int l;
    int r;
    int c;
  } exp_t;

  exp_t q5[$];
  exp_t q8[$];
  exp_t e5, e8;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   slew_exp [9] = '{874, 749, 624, 499, 374, 249, 124, 0, 0};

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Band 0 and the remaining bands get separate values; chk queues an expected result.
  task automatic applyStimulus(input int l0, input int lr, input int r0, input int rr,
                               input int p0, input int pr, input int vol,
                               input bit chk, input int exp_l, input int exp_r);
    for (int k = 0; k < NB; k++) begin
      band_lft[k*W +: W]  = 16'(k == 0 ? l0 : lr);
      band_rght[k*W +: W] = 16'(k == 0 ? r0 : rr);
      pot_band[k*12 +: 12] = 12'(k == 0 ? p0 : pr);
    end
    pot_vol  = 12'(vol);
    smpl_vld = 1'b1;
    if (chk) q5.push_back('{exp_l, exp_r, cyc});
    @(posedge clk);
    #1 smpl_vld = 1'b0;
  endtask

  task automatic applyStimulusWide(input int smp, input int pot, input int vol,
                                   input int exp_l, input int exp_r);
    for (int k = 0; k < NB8; k++) begin
      band8_lft[k*W +: W]   = 16'(smp);
      band8_rght[k*W +: W]  = 16'(smp);
      pot8_band[k*12 +: 12] = 12'(pot);
    end
    pot8_vol  = 12'(vol);
    smpl_vld8 = 1'b1;
    q8.push_back('{exp_l, exp_r, cyc});
    @(posedge clk);
    #1 smpl_vld8 = 1'b0;
  endtask

  task automatic pulseClear();
    clr_flags = 1'b1;
    @(posedge clk);
    #1 clr_flags = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      if (q5.size() == 0) begin
        checkOutput("unexpected_out_vld", 1, 0);
      end else begin
        e5 = q5.pop_front();
        checkOutput("aud_out_lft", aud_out_lft, e5.l);
        checkOutput("aud_out_rght", aud_out_rght, e5.r);
        checkOutput("latency", cyc - e5.c, 13);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out8_vld) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_out8_vld", 1, 0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("aud8_lft", aud8_lft, e8.l);
        checkOutput("aud8_rght", aud8_rght, e8.r);
        checkOutput("latency8", cyc - e8.c, 19);
      end
    end
  end

  initial begin
    rst_n = 1'b0; smpl_vld = 1'b0; clr_flags = 1'b0;
    band_lft = '0; band_rght = '0; pot_band = '0; pot_vol = '0;
    smpl_vld8 = 1'b0; clr_flags8 = 1'b0;
    band8_lft = '0; band8_rght = '0; pot8_band = '0; pot8_vol = '0;
    waitCycles(3);

    checkOutput("rst_aud_out_lft", aud_out_lft, 0);
    checkOutput("rst_aud_out_rght", aud_out_rght, 0);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);
    checkOutput("rst_ovr_flag", ovr_flag, 0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] unity mix");
    applyStimulus(1000, 1000, -1000, -1000, 2048, 2048, 4095, 1'b1, 4998, -4999);
    checkOutput("busy_after_accept", busy, 1);
    waitCycles(16);
    checkOutput("busy_idle", busy, 0);
    checkOutput("unity_sat_flag", sat_flag, 0);
    checkOutput("unity_ovr_flag", ovr_flag, 0);

    $display("[TB] overrun");
    applyStimulus(500, 500, 300, 300, 2048, 2048, 4095, 1'b1, 2499, 1499);
    waitCycles(3);
    for (int k = 0; k < NB; k++) begin
      band_lft[k*W +: W]   = 16'(7000);
      band_rght[k*W +: W]  = 16'(7000);
      pot_band[k*12 +: 12] = 12'(4095);
    end
    smpl_vld  = 1'b1;
    clr_flags = 1'b1;
    @(posedge clk);
    #1 smpl_vld = 1'b0;
    clr_flags = 1'b0;
    checkOutput("ovr_set_wins", ovr_flag, 1);
    waitCycles(14);
    checkOutput("ovr_sticky", ovr_flag, 1);
    pulseClear();
    checkOutput("ovr_cleared", ovr_flag, 0);

    $display("[TB] reset mid-MAC");
    applyStimulus(1000, 0, 0, 0, 0, 2048, 4095, 1'b0, 0, 0);
    waitCycles(3);
    rst_n = 1'b0;
    #2;
    checkOutput("abort_aud_out_lft", aud_out_lft, 0);
    checkOutput("abort_aud_out_rght", aud_out_rght, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_out_vld", out_vld, 0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(20);

    $display("[TB] gain slew");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1000, 0, 0, 0, 0, 2048, 4095, 1'b1, slew_exp[i], 0);
      waitCycles(15);
    end
    checkOutput("slew_sat_flag", sat_flag, 0);

    $display("[TB] saturation");
    applyStimulus(20000, 20000, -20000, -20000, 4095, 4095, 4095, 1'b1, 32767, -32768);
    waitCycles(15);
    checkOutput("sat_flag_set", sat_flag, 1);
    applyStimulus(-20000, -20000, 20000, 20000, 4095, 4095, 4095, 1'b1, -32768, 32767);
    waitCycles(15);
    pulseClear();
    checkOutput("sat_cleared", sat_flag, 0);

    $display("[TB] eight bands, immediate gains");
    applyStimulusWide(100, 4095, 4095, 1598, 1598);
    waitCycles(25);

    checkOutput("pending_q5", q5.size(), 0);
    checkOutput("pending_q8", q8.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
Name: eq_band_mixer

Overview:
- Parametrised, time-multiplexed successor to the fixed 5-band summing/volume stage of the equalizer engine.
- Accepts NUM_BANDS filtered band samples per stereo channel and applies a slew-limited per-band gain to each, removing zipper noise on pot moves.
- Accumulates through one shared multiplier, applies master volume, and saturates to W-bit output with a valid strobe.
- Sits between the FIR band filters and the output (PWM/I2S) path.

Parameters:
- NUM_BANDS, 5, number of bands mixed (2..16).
- W, 16, signed audio sample width in and out.
- GAIN_STEP, 256, maximum per-sample change of each band gain. 0 means gain tracks the pot immediately.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- smpl_vld  input  1  one-cycle strobe: new band samples are present on band_lft/band_rght.
- band_lft  input  NUM_BANDS*W  packed signed left band samples, band k at [k*W +: W].
- band_rght  input  NUM_BANDS*W  packed signed right band samples, same packing.
- pot_band  input  NUM_BANDS*12  unsigned band gain pots, band k at [k*12 +: 12]; 2048 = unity.
- pot_vol  input  12  unsigned master volume; output scaled by pot_vol/4096.
- clr_flags  input  1  synchronous clear of sat_flag and ovr_flag.
- aud_out_lft  output  W  signed mixed left output, registered.
- aud_out_rght  output  W  signed mixed right output, registered.
- out_vld  output  1  one-cycle strobe: aud_out_* updated this cycle.
- busy  output  1  high while not IDLE.
- sat_flag  output  1  sticky: an output was clamped.
- ovr_flag  output  1  sticky: smpl_vld arrived while busy and was dropped.

Behaviour:
- Reset is asynchronous and active-low; the clock is clk.
- Reset values: aud_out_lft/rght = 0, out_vld = 0, busy = 0, sat_flag = 0, ovr_flag = 0, state = IDLE, all gain registers g[k] = 2048, accumulators = 0.
- States: IDLE, MAC, VOL_L, VOL_R, OUT.
- IDLE, smpl_vld=1:
  - snapshot all band samples, pot_band and pot_vol into internal registers;
  - update every g[k] toward pot[k] by min(|pot[k]-g[k]|, GAIN_STEP), or set g[k]=pot[k] when GAIN_STEP=0;
  - clear both accumulators;
  - go to MAC.
- MAC: 2*NUM_BANDS cycles, using one shared signed multiplier (sample × {0,g[k]}).
  - Even step of band k: acc_l += band_lft[k]*g[k].
  - Odd step of band k: acc_r += band_rght[k]*g[k].
  - Bands are processed in order 0..NUM_BANDS-1, then the state goes to VOL_L.
  - Accumulator width is W+13+clog2(NUM_BANDS), so the accumulator never overflows.
- VOL_L: mix_l = acc_l >>> 11; prod_l = mix_l * {0,vol} >>> 12, using the same multiplier. VOL_R does the same for the right channel.
- All shifts are arithmetic, rounding toward negative infinity.
- OUT: aud_out_* take the saturated results, clamped to [-2^(W-1), 2^(W-1)-1]. out_vld=1 for exactly this cycle, then the state returns to IDLE.
- Latency: smpl_vld in cycle 0 gives out_vld in cycle 2*NUM_BANDS+3 (13 for the defaults).
- aud_out_* hold their value between strobes. busy is high from cycle 1 through the OUT cycle inclusive.
- Minimum smpl_vld spacing is 2*NUM_BANDS+4 cycles.
- smpl_vld while busy (including the OUT cycle): the sample is dropped, ovr_flag is set, and the in-flight computation is unaffected.
- Saturation on either channel sets sat_flag.
- clr_flags clears both sticky flags. If clr_flags coincides with a new set event, the set wins.
- Gains update only on accepted samples; pot changes while busy are ignored until the next accept.
- Asserting rst_n low mid-operation immediately forces the reset values; no out_vld is produced for the aborted sample.

Test Plan:
- Unity mix: all pots 2048, pot_vol 4095, all left bands 1000, all right bands -1000, one smpl_vld -> out_vld exactly 13 cycles later, aud_out_lft=4998, aud_out_rght=-4999, flags 0.
- Saturation:
  - all bands 20000, pots 4095 (after gains have slewed up), vol 4095 -> aud_out_lft=32767, sat_flag=1;
  - bands -20000 -> aud_out_lft=-32768;
  - clr_flags -> sat_flag=0.
- Gain slew (GAIN_STEP=256): band0 only =1000, vol 4095, pot0 held at 0 from reset -> successive outputs use gains 1792, 1536, …, 0 (outputs 874, 749, …, 0), reaching 0 on the 8th sample and staying there.
- Overrun: second smpl_vld 5 cycles after the first -> ovr_flag=1, only one out_vld pulse, value equal to the first sample's result; clr_flags clears ovr_flag.
- Reset mid-MAC: assert rst_n low at cycle 4 after smpl_vld -> outputs 0, busy 0, no out_vld; the next sample after release produces the correct result with all gains starting from 2048.
- NUM_BANDS=8, GAIN_STEP=0: bands 100 each, pots 4095, vol 4095 -> gains apply immediately, out_vld at cycle 19, aud_out_lft=1598.
